// File: rtl/sequential_divider_32by16_pkg.sv
// Shared definitions for the 32-by-16 sequential divider: default operand
// width, FSM state encoding and the step-counter width.
package divider_pkg;

    // Divisor / quotient / remainder width; the dividend is twice as wide.
    localparam int DW_DEFAULT = 16;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count DW iterations (0 .. DW-1).
    function automatic int step_cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int CNT_W = step_cnt_w(DW_DEFAULT);

endpackage

// File: rtl/sequential_divider_32by16_if.sv
// Request/result bundle of the sequential divider.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds valid and its payload until that edge and may
// not withdraw valid early; the sink may drive ready without looking at valid.
// Request side: in_valid/in_ready carry dividend/divisor into the divider.
// Result side: out_valid/out_ready carry quotient/remainder/flags out of it.
interface sequential_divider_32by16_if
    import divider_pkg::*;
    #(parameter int DW = DW_DEFAULT) ();

    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            div_by_zero;
    logic            overflow;

    // Requester / result consumer side.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    // Divider side.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/sequential_divider_32by16_div_step.sv
// One restoring radix-2 division iteration (purely combinational).
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module div_step
    import divider_pkg::*;
    #(parameter int DW = DW_DEFAULT) (
    input  logic [DW-1:0] i_rem,
    input  logic          i_bit,
    input  logic [DW-1:0] i_divisor,
    output logic [DW-1:0] o_rem,
    output logic          o_qbit
);

    // The shifted remainder needs DW+1 bits: i_rem can be up to divisor-1,
    // so doubling it would lose the carry in a DW-bit value.
    logic [DW:0] w_shift;
    logic [DW:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // With i_rem < i_divisor, w_shift < 2*divisor, so a non-negative
    // difference always has its MSB clear and a negative one has it set.
    assign o_qbit = ~w_diff[DW];
    assign o_rem  = o_qbit ? w_diff[DW-1:0] : w_shift[DW-1:0];

endmodule

// File: rtl/sequential_divider_32by16.sv
// Sequential unsigned divider: 2*DW-bit dividend by DW-bit divisor,
// one restoring step per clock, DW+1 cycles from accept to result.
// Divide-by-zero and quotient overflow finish one cycle after accept.
// Optional macro DIV_FAST_ZERO_EN: a zero dividend (non-zero divisor) also
// finishes one cycle after accept; without it, it runs the full iteration.
module sequential_divider_32by16
    import divider_pkg::*;
    #(parameter int DW = DW_DEFAULT) (
    input  logic                         clk,
    input  logic                         rst,
    sequential_divider_32by16_if.slave   bus,
    output state_t                       o_dbg_state
);

    localparam int            CW        = step_cnt_w(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    state_t        r_state;
    state_t        w_next_state;

    logic [DW-1:0] r_divisor;
    logic [DW-1:0] r_rem;       // partial remainder, always < r_divisor
    logic [DW-1:0] r_lo;        // remaining dividend bits, quotient shifts in
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quot;
    logic [DW-1:0] r_rem_out;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_consume;
    logic          w_last_step;
    logic          w_is_dbz;
    logic          w_is_ovf;
    logic          w_is_zero;
    logic          w_early;
    logic [DW-1:0] w_step_rem;
    logic          w_step_q;

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_consume   = w_out_valid & bus.out_ready;
    assign w_last_step = (r_cnt == LAST_STEP);

    assign w_is_dbz = (bus.divisor == '0);
    // The quotient fits in DW bits only if the upper dividend half is below
    // the divisor; this also guarantees the r_rem < r_divisor invariant.
    assign w_is_ovf = !w_is_dbz && (bus.dividend[2*DW-1:DW] >= bus.divisor);
`ifdef DIV_FAST_ZERO_EN
    assign w_is_zero = !w_is_dbz && (bus.dividend == '0);
`else
    assign w_is_zero = 1'b0;
`endif
    assign w_early = w_is_dbz | w_is_ovf | w_is_zero;

    // Single iteration stage, reused every RUN cycle.
    div_step #(.DW(DW)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_lo[DW-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept -> RUN (or straight to DONE), DW steps, hold for consumer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_next_state = w_early ? DONE : RUN;
            RUN:     if (w_last_step) w_next_state = DONE;
            DONE:    if (w_consume)   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            DONE:    w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_divisor <= '0;
            r_rem     <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= bus.divisor;
            r_rem     <= bus.dividend[2*DW-1:DW];
            r_lo      <= bus.dividend[DW-1:0];
            r_cnt     <= '0;
            r_dbz     <= w_is_dbz;
            r_ovf     <= w_is_ovf;
            if (w_is_dbz || w_is_ovf) begin
                r_quot    <= '1;
                r_rem_out <= bus.dividend[DW-1:0];
            end else if (w_is_zero) begin
                r_quot    <= '0;
                r_rem_out <= '0;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_step_rem;
            r_lo  <= {r_lo[DW-2:0], w_step_q};
            r_cnt <= r_cnt + CW'(1);
            if (w_last_step) begin
                r_quot    <= {r_lo[DW-2:0], w_step_q};
                r_rem_out <= w_step_rem;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem_out;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_sequential_divider_32by16.sv
// Directed testbench for sequential_divider_32by16.
// Honors DIV_FAST_ZERO_EN for the expected zero-dividend latency.
module tb_sequential_divider_32by16;
    import divider_pkg::*;

    localparam int DW = 16;
`ifdef DIV_FAST_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = DW + 1;
`endif
    localparam int NORM_LAT = DW + 1;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_pass;
    int     n_total;

    sequential_divider_32by16_if #(.DW(DW)) bus ();

    sequential_divider_32by16 #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    // Present one request, return edges from accept (inclusive) to out_valid.
    // Inputs are scrambled right after accept: the divider must not notice.
    task automatic drive_request(input logic [2*DW-1:0] dvd, input logic [DW-1:0] dvs,
                                 output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom_range(65535, 0));
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.quotient !== 16'h0) $display("FAIL reset_quotient: got %h want 0000", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 16'h0) $display("FAIL reset_remainder: got %h want 0000", bus.remainder); else n_pass++;
        n_total++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {bus.div_by_zero, bus.overflow}); else n_pass++;
        n_total++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_normal();
        logic [2*DW-1:0] dvd [6];
        logic [DW-1:0]   dvs [6];
        logic [DW-1:0]   eq  [6];
        logic [DW-1:0]   er  [6];
        int              lat;
        dvd = '{32'd6000000, 32'd4294836225, 32'hFFFE_FFFF, 32'd1000, 32'd123456789, 32'h0000_FFFF};
        dvs = '{16'd3000,    16'd65535,      16'hFFFF,      16'd1,    16'd12345,     16'hFFFF};
        eq  = '{16'd2000,    16'd65535,      16'hFFFF,      16'd1000, 16'd10000,     16'd1};
        er  = '{16'd0,       16'd0,          16'hFFFE,      16'd0,    16'd6789,      16'd0};
        for (int i = 0; i < 6; i++) begin
            drive_request(dvd[i], dvs[i], lat);
            n_total++; if (lat !== NORM_LAT) $display("FAIL normal%0d_latency: got %0d want %0d", i, lat, NORM_LAT); else n_pass++;
            n_total++; if (bus.quotient !== eq[i]) $display("FAIL normal%0d_quotient: got %0d want %0d", i, bus.quotient, eq[i]); else n_pass++;
            n_total++; if (bus.remainder !== er[i]) $display("FAIL normal%0d_remainder: got %0d want %0d", i, bus.remainder, er[i]); else n_pass++;
            n_total++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) $display("FAIL normal%0d_flags: got %b want 00", i, {bus.div_by_zero, bus.overflow}); else n_pass++;
            consume();
            n_total++; if (bus.out_valid !== 1'b0) $display("FAIL normal%0d_consumed: out_valid got %b want 0", i, bus.out_valid); else n_pass++;
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        drive_request(32'd12345, 16'd0, lat);
        n_total++; if (lat !== 1) $display("FAIL dbz_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL dbz_ovf_flag: got %b want 0", bus.overflow); else n_pass++;
        n_total++; if (bus.quotient !== 16'hFFFF) $display("FAIL dbz_quotient: got %h want ffff", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 16'd12345) $display("FAIL dbz_remainder: got %0d want 12345", bus.remainder); else n_pass++;
        consume();
        drive_request(32'hDEAD_BEEF, 16'd0, lat);
        n_total++; if (bus.remainder !== 16'hBEEF) $display("FAIL dbz2_remainder: got %h want beef", bus.remainder); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dbz2_flag: got %b want 1", bus.div_by_zero); else n_pass++;
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        drive_request(32'h0001_0000, 16'd1, lat);
        n_total++; if (lat !== 1) $display("FAIL ovf_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.overflow); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL ovf_dbz_flag: got %b want 0", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.quotient !== 16'hFFFF) $display("FAIL ovf_quotient: got %h want ffff", bus.quotient); else n_pass++;
        n_total++; if (bus.remainder !== 16'h0) $display("FAIL ovf_remainder: got %h want 0000", bus.remainder); else n_pass++;
        consume();
        // Upper half exactly equal to the divisor is already an overflow.
        drive_request(32'hFFFF_1234, 16'hFFFF, lat);
        n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_equal_flag: got %b want 1", bus.overflow); else n_pass++;
        n_total++; if (bus.remainder !== 16'h1234) $display("FAIL ovf_equal_remainder: got %h want 1234", bus.remainder); else n_pass++;
        consume();
    endtask

    // Hold the result, then consume with a new request pending: it must be
    // accepted only on the edge after the consume.
    task automatic test_backpressure();
        int lat;
        drive_request(32'd357, 16'd17, lat);
        n_total++; if (lat !== NORM_LAT) $display("FAIL bp_latency: got %0d want %0d", lat, NORM_LAT); else n_pass++;
        bus.in_valid = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 16'd7;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.quotient !== 16'd21 || bus.remainder !== 16'd0 || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%b q=%0d r=%0d rdy=%b want v=1 q=21 r=0 rdy=0",
                         c, bus.out_valid, bus.quotient, bus.remainder, bus.in_ready);
            else
                n_pass++;
        end
        consume();
        n_total++; if (dbg_state !== IDLE) $display("FAIL b2b_no_accept_on_consume: state got %0d want %0d", dbg_state, IDLE); else n_pass++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_total++; if (dbg_state !== RUN) $display("FAIL b2b_accept_next_edge: state got %0d want %0d", dbg_state, RUN); else n_pass++;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_total++; if (lat !== NORM_LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, NORM_LAT); else n_pass++;
        n_total++; if (bus.quotient !== 16'd14 || bus.remainder !== 16'd2) $display("FAIL b2b_result: got q=%0d r=%0d want q=14 r=2", bus.quotient, bus.remainder); else n_pass++;
        consume();
    endtask

    task automatic test_reset_abort();
        int lat;
        bit stale;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 32'd6000000;
        bus.divisor  = 16'd3000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (dbg_state !== IDLE || bus.out_valid !== 1'b0) $display("FAIL abort_run_state: got state=%0d v=%b want state=%0d v=0", dbg_state, bus.out_valid, IDLE); else n_pass++;
        n_total++; if (bus.quotient !== 16'h0 || bus.in_ready !== 1'b1) $display("FAIL abort_run_outputs: got q=%h rdy=%b want q=0000 rdy=1", bus.quotient, bus.in_ready); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        n_total++; if (stale !== 1'b0) $display("FAIL abort_no_stale_result: got 1 want 0"); else n_pass++;
        drive_request(32'd100, 16'd7, lat);
        n_total++; if (lat !== NORM_LAT) $display("FAIL after_abort_latency: got %0d want %0d", lat, NORM_LAT); else n_pass++;
        n_total++; if (bus.quotient !== 16'd14 || bus.remainder !== 16'd2) $display("FAIL after_abort_result: got q=%0d r=%0d want q=14 r=2", bus.quotient, bus.remainder); else n_pass++;
        // Reset while the result is waiting drops it.
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (bus.out_valid !== 1'b0 || bus.remainder !== 16'h0) $display("FAIL abort_done: got v=%b r=%h want v=0 r=0000", bus.out_valid, bus.remainder); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero_dividend();
        int lat;
        drive_request(32'd0, 16'd7, lat);
        n_total++; if (lat !== ZERO_LAT) $display("FAIL zero_latency: got %0d want %0d", lat, ZERO_LAT); else n_pass++;
        n_total++; if (bus.quotient !== 16'h0 || bus.remainder !== 16'h0) $display("FAIL zero_result: got q=%h r=%h want q=0000 r=0000", bus.quotient, bus.remainder); else n_pass++;
        n_total++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) $display("FAIL zero_flags: got %b want 00", {bus.div_by_zero, bus.overflow}); else n_pass++;
        consume();
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        test_reset();
        test_normal();
        test_div_by_zero();
        test_overflow();
        test_backpressure();
        test_reset_abort();
        test_zero_dividend();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sequential_divider_32by16.md
SEQUENTIAL_DIVIDER_32BY16 -- requirements
Module: sequential_divider_32by16

Interface
REQ-001 SHALL have parameter: DW, 16, divisor/quotient/remainder width; dividend width is 2*DW.
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  dividend/divisor valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts a request.
REQ-006 SHALL have port: dividend  input  2*DW  unsigned dividend, e.g. a multiplier product.
REQ-007 SHALL have port: divisor  input  DW  unsigned divisor.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port: quotient  output  DW  unsigned quotient.
REQ-011 SHALL have port: remainder  output  DW  unsigned remainder.
REQ-012 SHALL have port: div_by_zero  output  1  divisor was 0.
REQ-013 SHALL have port: overflow  output  1  quotient does not fit in DW bits (dividend[2DW-1:DW] >= divisor, divisor != 0).

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state == IDLE).
REQ-015 SHALL accept a request on a rising edge with in_valid & in_ready, capture operands, then enter RUN, or enter DONE directly if divisor == 0 or overflow.
REQ-016 SHALL perform one restoring radix-2 step per RUN cycle, DW steps total, with a DW+1-bit partial remainder to avoid carry loss.
REQ-017 SHALL give normal latency: out_valid rises DW+1 edges after the accept edge (17 for DW=16).
REQ-018 SHALL give divide-by-zero/overflow latency: out_valid rises 1 edge after accept; quotient = all-ones, remainder = dividend[DW-1:0], matching flag = 1.
REQ-019 SHALL hold out_valid and all result outputs stable in DONE until out_valid & out_ready; that edge returns the FSM to IDLE.
REQ-020 SHALL NOT accept a new request in the same cycle a result is consumed; the next accept is possible one edge later.
REQ-021 SHALL clear flags on every accept; flags are meaningful only while out_valid = 1.
REQ-022 SHALL ignore in_valid, dividend and divisor outside IDLE; captured operands are immune to input changes.

Reset
REQ-023 SHALL, on rst low, asynchronously force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, step counter=0.
REQ-024 SHALL abort an in-flight division on reset mid-RUN or mid-DONE with no result delivered; the first accept after reset release is processed normally.

Configuration
REQ-025 SHALL use macro DIV_FAST_ZERO_EN: when defined, a dividend of 0 with divisor != 0 goes straight to DONE (latency 1, quotient 0, remainder 0); when undefined, a zero dividend takes the full DW+1 latency with the same numeric result.

Structure
REQ-026 SHALL place DW default, FSM state enum (IDLE/RUN/DONE) and the step-counter width constant in shared package divider_pkg.
REQ-027 SHALL implement one restoring iteration as combinational sub-module div_step (partial remainder, dividend bit, divisor -> next remainder, quotient bit), instantiated once and reused each RUN cycle.

Verification
REQ-028 SHALL test: dividend 6000000, divisor 3000 -> quotient 2000, remainder 0, flags 0, out_valid at accept+17.
REQ-029 SHALL test: dividend 4294836225, divisor 65535 -> quotient 65535, remainder 0, overflow 0.
REQ-030 SHALL test: dividend 12345, divisor 0 -> div_by_zero 1, quotient 0xFFFF, remainder 12345, out_valid at accept+1.
REQ-031 SHALL test: dividend 0x00010000, divisor 1 -> overflow 1, quotient 0xFFFF, remainder 0, latency 1.
REQ-032 SHALL test: out_ready held low 10 cycles after out_valid (dividend 21*17=357, divisor 17) -> outputs stable at quotient 21, remainder 0; in_ready low until consume.
REQ-033 SHALL test: rst low at accept+5, then release and apply dividend 100, divisor 7 -> no stale out_valid, result quotient 14, remainder 2; repeat with dividend 0 -> latency 1 with DIV_FAST_ZERO_EN, 17 without.
